// File: rtl/dec_digits_if.sv
// Operand/digit handshake bundle for dec_digits: operand in (v/a/ri), digits out (d/dv/dl/dr).
// master = upstream producer plus downstream digit consumer; slave = the extractor.
interface dec_digits_if #(parameter int W = 20);
  logic         v;
  logic [W-1:0] a;
  logic         ri;
  logic [3:0]   d;
  logic         dv;
  logic         dl;
  logic         dr;

  modport master (output v, a, dr, input ri, d, dv, dl);
  modport slave  (input v, a, dr, output ri, d, dv, dl);
endinterface

// File: rtl/dec_digits.sv
// Bit-serial binary-to-decimal digit extractor: restoring divide-by-10, one quotient bit per clock,
// digits emitted LSD first. Optional macro DEC_PAD_EN zero-pads every operand to N_DIG digits.
module dec_digits #(
  parameter int W     = 20,
  parameter int N_DIG = 7
) (
  input  logic         t,
  input  logic         c,
  dec_digits_if.slave  bus
);
  localparam int KW = $clog2(W);

  if (N_DIG < 1) begin : g_cfg_err
    $error("N_DIG must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_EMIT} state_t;

  state_t          r_state;
  logic [W-1:0]    r_q;
  logic [4:0]      r_rm;
  logic [KW-1:0]   r_k;
  logic            r_ri;
  logic            r_dv;
  logic            r_dl;
  logic [3:0]      r_d;
`ifdef DEC_PAD_EN
  logic [2:0]      r_cnt;
`endif

  logic [4:0]      w_rm_sh;
  logic            w_ge;
  logic [4:0]      w_rm_n;
  logic [W-1:0]    w_q_n;
  logic            w_last;

  // One restoring step: remainder stays <= 9, so 5 bits cover the shifted value.
  assign w_rm_sh = {r_rm[3:0], r_q[W-1]};
  assign w_ge    = (w_rm_sh >= 5'd10);
  assign w_rm_n  = w_ge ? (w_rm_sh - 5'd10) : w_rm_sh;
  assign w_q_n   = {r_q[W-2:0], w_ge};
`ifdef DEC_PAD_EN
  assign w_last  = (r_cnt == 3'(N_DIG - 1));
`else
  assign w_last  = (w_q_n == '0);
`endif

  always_ff @(posedge t or posedge c) begin
    if (c) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_rm    <= '0;
      r_k     <= '0;
      r_ri    <= 1'b0;
      r_dv    <= 1'b0;
      r_dl    <= 1'b0;
      r_d     <= '0;
`ifdef DEC_PAD_EN
      r_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ri <= 1'b1;
          if (r_ri && bus.v) begin
            r_q     <= bus.a;
            r_rm    <= '0;
            r_k     <= KW'(W - 1);
            r_ri    <= 1'b0;
            r_state <= S_DIV;
`ifdef DEC_PAD_EN
            r_cnt   <= '0;
`endif
          end
        end
        S_DIV: begin
          r_q  <= w_q_n;
          r_rm <= w_rm_n;
          r_k  <= r_k - 1'b1;
          if (r_k == '0) begin
            r_state <= S_EMIT;
            r_dv    <= 1'b1;
            r_d     <= w_rm_n[3:0];
            r_dl    <= w_last;
          end
        end
        S_EMIT: begin
          if (bus.dr) begin
            r_dv <= 1'b0;
            r_d  <= '0;
            r_dl <= 1'b0;
            if (r_dl) begin
              r_ri    <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              // Quotient is kept: the next pass divides what is left by 10 again.
              r_rm    <= '0;
              r_k     <= KW'(W - 1);
              r_state <= S_DIV;
`ifdef DEC_PAD_EN
              r_cnt   <= r_cnt + 1'b1;
`endif
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ri = r_ri;
  assign bus.dv = r_dv;
  assign bus.d  = r_d;
  assign bus.dl = r_dl;
endmodule

// File: tb/tb_dec_digits.sv
// Scoreboard bench for dec_digits: expected digits queued at operand drive, popped on each dv&dr handshake.
module tb_dec_digits;
  localparam int W     = 20;
  localparam int N_DIG = 7;

  logic t = 1'b0;
  logic c = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [4:0] sb[$];
  logic [4:0] mon_e;

  dec_digits_if #(.W(W)) bus();

  dec_digits #(.W(W), .N_DIG(N_DIG)) dut (
    .t   (t),
    .c   (c),
    .bus (bus)
  );

  always #5 t = ~t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference digits via plain % and / arithmetic, packed as {last, digit}.
  task automatic push_expected(input int unsigned val);
    int unsigned x = val;
    int n = 0;
    logic last;
    do begin
      n++;
      last = 1'b0;
`ifdef DEC_PAD_EN
      if (n == N_DIG) last = 1'b1;
`else
      if (x / 10 == 0) last = 1'b1;
`endif
      sb.push_back({last, 4'(x % 10)});
      x = x / 10;
    end while (!last);
  endtask

  task automatic accept(input int unsigned val);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge t);
      if (bus.ri) break;
    end
    check("accept_ri", {31'd0, bus.ri}, 1);
    bus.v = 1'b1;
    bus.a = W'(val);
    push_expected(val);
    $display("accept a=%0d", val);
    @(posedge t);
    #1 bus.v = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      @(negedge t);
      if (sb.size() == 0 && bus.ri) break;
    end
    check("done_sb_empty", sb.size(), 0);
    check("done_ri", {31'd0, bus.ri}, 1);
  endtask

  always @(negedge t) begin
    if (!c && bus.dv && bus.dr) begin
      if (sb.size() == 0) begin
        check("extra_digit", {31'd0, bus.dv}, 0);
      end else begin
        mon_e = sb.pop_front();
        $display("digit d=%0d dl=%0b exp d=%0d dl=%0b", bus.d, bus.dl, mon_e[3:0], mon_e[4]);
        check("digit", {28'd0, bus.d}, {28'd0, mon_e[3:0]});
        check("last", {31'd0, bus.dl}, {31'd0, mon_e[4]});
        if (mon_e[4]) begin
          @(negedge t);
          check("ri_after_last", {31'd0, bus.ri}, 1);
          check("dv_after_last", {31'd0, bus.dv}, 0);
        end
      end
    end
  end

  initial begin
    int i;
    bus.v  = 1'b0;
    bus.a  = '0;
    bus.dr = 1'b1;

    // Reset state and ri release timing
    repeat (3) @(posedge t);
    @(negedge t);
    check("rst_ri", {31'd0, bus.ri}, 0);
    check("rst_dv", {31'd0, bus.dv}, 0);
    check("rst_d", {28'd0, bus.d}, 0);
    check("rst_dl", {31'd0, bus.dl}, 0);
    @(posedge t);
    #1 c = 1'b0;
    #1 check("rel_ri_before_edge", {31'd0, bus.ri}, 0);
    @(posedge t);
    #1 check("rel_ri_after_edge", {31'd0, bus.ri}, 1);

    // 72897 with first-digit latency measurement
    accept(72897);
    for (i = 1; i <= 30; i++) begin
      @(posedge t);
      #1 if (bus.dv) break;
    end
    check("first_dv_latency", i, W);
    wait_done();

    // Zero operand, then back-to-back 524
    accept(0);
    accept(524);
    wait_done();

    // Maximum operand
    accept(1048575);
    wait_done();

    // Back-pressure on first digit of 61, with v pulses while busy
    @(posedge t);
    #1 bus.dr = 1'b0;
    accept(61);
    for (i = 0; i < 100; i++) begin
      @(negedge t);
      if (bus.dv) break;
    end
    for (int k = 0; k < 6; k++) begin
      check("hold_dv", {31'd0, bus.dv}, 1);
      check("hold_d", {28'd0, bus.d}, 61 % 10);
      bus.v = (k == 2 || k == 3);
      bus.a = W'(999);
      @(negedge t);
    end
    bus.v = 1'b0;
    @(posedge t);
    #1 bus.dr = 1'b1;
    wait_done();
    repeat (50) @(posedge t);
    check("no_spurious", sb.size(), 0);

    // Asynchronous reset mid-DIV, then recover with 139
    accept(72897);
    repeat (10) @(posedge t);
    #3 c = 1'b1;
    #1;
    check("arst_dv", {31'd0, bus.dv}, 0);
    check("arst_d", {28'd0, bus.d}, 0);
    check("arst_dl", {31'd0, bus.dl}, 0);
    check("arst_ri", {31'd0, bus.ri}, 0);
    sb.delete();
    @(posedge t);
    #1 c = 1'b0;
    @(posedge t);
    #1 check("arst_ri_release", {31'd0, bus.ri}, 1);
    accept(139);
    wait_done();
    repeat (30) @(posedge t);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
